// File: rtl/cordic_nco_pkg.sv
// Shared constants and constant functions for the TDM CORDIC NCO.
//   - CORDIC_K       : aggregate CORDIC gain compensation factor
//   - quad_e         : encoding of the two phase MSBs (quadrant)
//   - quad_needs_fold: quadrants that are folded by half a circle
//   - atan_angle()   : micro-rotation angle for stage idx in phase units
//   - x0_from_amp()  : pre-scaled start value that yields amplitude amp
package cordic_nco_pkg;

  localparam real CORDIC_K = 0.6072529;
  localparam real PI       = 3.14159265358979323846;

  typedef enum logic [1:0] {
    QUAD_0 = 2'b00,
    QUAD_1 = 2'b01,
    QUAD_2 = 2'b10,
    QUAD_3 = 2'b11
  } quad_e;

  // Quadrants 1 and 2 lie outside [-90, 90) degrees. They are rotated by
  // half a circle, and the result is negated afterwards.
  function automatic logic quad_needs_fold(input quad_e q);
    return (q == QUAD_1) || (q == QUAD_2);
  endfunction

  // round(atan(2^-idx) * 2^phase_w / (2*pi)).
  // The arctangent is built from its power series so that the function only
  // needs plain real arithmetic during elaboration.
  function automatic int atan_angle(input int idx, input int phase_w);
    real x;
    real xp;
    real x2;
    real sum;
    real scale;
    x = 1.0;
    for (int k = 0; k < idx; k++) x = x / 2.0;
    if (idx == 0) begin
      sum = PI / 4.0;
    end else begin
      sum = 0.0;
      xp  = x;
      x2  = x * x;
      for (int n = 0; n < 40; n++) begin
        if ((n % 2) == 0) sum = sum + xp / real'(2 * n + 1);
        else              sum = sum - xp / real'(2 * n + 1);
        xp = xp * x2;
      end
    end
    scale = 1.0;
    for (int k = 0; k < phase_w; k++) scale = scale * 2.0;
    return $rtoi(sum * scale / (2.0 * PI) + 0.5);
  endfunction

  // The start vector is pre-shrunk by K so the rotated output magnitude is amp.
  function automatic int x0_from_amp(input int amp);
    return $rtoi(real'(amp) * CORDIC_K + 0.5);
  endfunction

endpackage

// File: rtl/cordic_nco_tdm_rot_stage.sv
// One registered CORDIC micro-rotation stage (rotation mode).
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_x, i_y, i_z      incoming vector and residual angle
//   i_val, i_neg, i_ch sideband: valid, fold flag, channel tag
//   o_*                the same set, registered after one micro-rotation
module cordic_rot_stage #(
  parameter int XW    = 18,
  parameter int ZW    = 16,
  parameter int CHW   = 2,
  parameter int SHIFT = 0,
  parameter int ANGLE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic signed [XW-1:0] i_x,
  input  logic signed [XW-1:0] i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic                 i_val,
  input  logic                 i_neg,
  input  logic [CHW-1:0]       i_ch,
  output logic signed [XW-1:0] o_x,
  output logic signed [XW-1:0] o_y,
  output logic signed [ZW-1:0] o_z,
  output logic                 o_val,
  output logic                 o_neg,
  output logic [CHW-1:0]       o_ch
);

  localparam logic signed [ZW-1:0] ANG = ZW'(ANGLE);

  logic                 w_pos;
  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;

  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic signed [ZW-1:0] r_z;
  logic                 r_val;
  logic                 r_neg;
  logic [CHW-1:0]       r_ch;

  // z >= 0 rotates counter-clockwise (d = +1).
  assign w_pos = ~i_z[ZW-1];
  assign w_xs  = i_x >>> SHIFT;
  assign w_ys  = i_y >>> SHIFT;

  always_ff @(posedge i_clk) begin
    // NOTE: only the valid bit is reset; data registers are don't-care while
    // their valid is low, so resetting them would only add reset fan-out.
    if (i_rst) r_val <= 1'b0;
    else       r_val <= i_val;
    r_x   <= w_pos ? (i_x - w_ys) : (i_x + w_ys);
    r_y   <= w_pos ? (i_y + w_xs) : (i_y - w_xs);
    r_z   <= w_pos ? (i_z - ANG)  : (i_z + ANG);
    r_neg <= i_neg;
    r_ch  <= i_ch;
  end

  assign o_x   = r_x;
  assign o_y   = r_y;
  assign o_z   = r_z;
  assign o_val = r_val;
  assign o_neg = r_neg;
  assign o_ch  = r_ch;

endmodule

// File: rtl/cordic_nco_tdm.sv
// Multi-channel TDM CORDIC NCO. CH_NUM phase accumulators are issued
// round-robin into one shared pipelined CORDIC rotator. Each output sample is
// tagged with its channel. The latency from issue to val_o is ITER_NUM+3.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   en_i                  issue one channel per cycle while high
//   phase_clr_i           zero all phase accumulators
//   cfg_we_i/cfg_ch_i     config write strobe / target channel
//   cfg_inc_i/cfg_ofs_i   phase increment / phase offset for that channel
//   cos_o, sin_o          signed outputs (sin_o is -sin when EN_SIN_N)
//   ch_o, val_o           channel tag and valid of the current output
module cordic_nco_tdm
  import cordic_nco_pkg::*;
#(
  parameter int  CH_NUM   = 4,
  parameter int  P_INC_W  = 16,
  parameter int  ODAT_W   = 16,
  parameter int  ITER_NUM = 16,
  parameter int  AMP      = 32000,
  parameter bit  EN_SIN_N = 1'b0,
  localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     phase_clr_i,
  input  logic                     cfg_we_i,
  input  logic [CH_W-1:0]          cfg_ch_i,
  input  logic [P_INC_W-1:0]       cfg_inc_i,
  input  logic [P_INC_W-1:0]       cfg_ofs_i,
  output logic signed [ODAT_W-1:0] cos_o,
  output logic signed [ODAT_W-1:0] sin_o,
  output logic [CH_W-1:0]          ch_o,
  output logic                     val_o
);

  localparam int XW = ODAT_W + 2;
  localparam logic signed [XW-1:0]  X0      = XW'(x0_from_amp(AMP));
  localparam logic [P_INC_W-1:0]    HALF    = {1'b1, {(P_INC_W-1){1'b0}}};
  localparam logic signed [XW-1:0]  SAT_MAX = XW'((2 ** (ODAT_W - 1)) - 1);
  localparam logic signed [XW-1:0]  SAT_MIN = XW'(-(2 ** (ODAT_W - 1)));

  // ---------------------------------------------------------------------
  // Sequencer and per-channel registers
  // ---------------------------------------------------------------------
  logic [CH_W-1:0]    r_ptr;
  logic [P_INC_W-1:0] r_acc [CH_NUM];
  logic [P_INC_W-1:0] r_inc [CH_NUM];
  logic [P_INC_W-1:0] r_ofs [CH_NUM];
  logic               w_cfg_hit;

  // Writes to channel indices that do not exist are dropped.
  assign w_cfg_hit = cfg_we_i && (int'(cfg_ch_i) < CH_NUM);

  always_ff @(posedge clk_i) begin
    if (rst_i)                              r_ptr <= '0;
    else if (en_i && int'(r_ptr) == CH_NUM - 1) r_ptr <= '0;
    else if (en_i)                          r_ptr <= r_ptr + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: this small register file has a reset loop, unlike a RAM, because
    // every channel must restart from a known zero phase and zero config.
    if (rst_i) begin
      for (int c = 0; c < CH_NUM; c++) begin
        r_acc[c] <= '0;
        r_inc[c] <= '0;
        r_ofs[c] <= '0;
      end
    end else begin
      // A clear wins over the issuing channel's accumulator update.
      if (phase_clr_i) begin
        for (int c = 0; c < CH_NUM; c++) r_acc[c] <= '0;
      end else if (en_i) begin
        r_acc[r_ptr] <= r_acc[r_ptr] + r_inc[r_ptr];
      end
      // The issue in this cycle has already read the old inc/ofs.
      if (w_cfg_hit) begin
        r_inc[cfg_ch_i] <= cfg_inc_i;
        r_ofs[cfg_ch_i] <= cfg_ofs_i;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage A: phase = acc + ofs of the issued channel
  // ---------------------------------------------------------------------
  logic [P_INC_W-1:0] r_a_phase;
  logic [CH_W-1:0]    r_a_ch;
  logic               r_a_val;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_a_val <= 1'b0;
    else       r_a_val <= en_i;
    r_a_phase <= r_acc[r_ptr] + r_ofs[r_ptr];
    r_a_ch    <= r_ptr;
  end

  // ---------------------------------------------------------------------
  // Stage B: fold into [-90, 90) degrees
  // ---------------------------------------------------------------------
  quad_e                      w_quad;
  logic                       w_fold;
  logic signed [P_INC_W-1:0]  r_b_z;
  logic                       r_b_neg;
  logic [CH_W-1:0]            r_b_ch;
  logic                       r_b_val;

  assign w_quad = quad_e'(r_a_phase[P_INC_W-1 -: 2]);
  assign w_fold = quad_needs_fold(w_quad);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_b_val <= 1'b0;
    else       r_b_val <= r_a_val;
    r_b_z   <= w_fold ? (r_a_phase - HALF) : r_a_phase;
    r_b_neg <= w_fold;
    r_b_ch  <= r_a_ch;
  end

  // ---------------------------------------------------------------------
  // CORDIC rotator chain
  // ---------------------------------------------------------------------
  logic signed [XW-1:0]      w_x   [ITER_NUM+1];
  logic signed [XW-1:0]      w_y   [ITER_NUM+1];
  logic signed [P_INC_W-1:0] w_z   [ITER_NUM+1];
  logic                      w_val [ITER_NUM+1];
  logic                      w_neg [ITER_NUM+1];
  logic [CH_W-1:0]           w_ch  [ITER_NUM+1];

  assign w_x[0]   = X0;
  assign w_y[0]   = '0;
  assign w_z[0]   = r_b_z;
  assign w_val[0] = r_b_val;
  assign w_neg[0] = r_b_neg;
  assign w_ch[0]  = r_b_ch;

  for (genvar i = 0; i < ITER_NUM; i++) begin : g_stage
    cordic_rot_stage #(
      .XW    (XW),
      .ZW    (P_INC_W),
      .CHW   (CH_W),
      .SHIFT (i),
      .ANGLE (atan_angle(i, P_INC_W))
    ) u_stage (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_x   (w_x[i]),
      .i_y   (w_y[i]),
      .i_z   (w_z[i]),
      .i_val (w_val[i]),
      .i_neg (w_neg[i]),
      .i_ch  (w_ch[i]),
      .o_x   (w_x[i+1]),
      .o_y   (w_y[i+1]),
      .o_z   (w_z[i+1]),
      .o_val (w_val[i+1]),
      .o_neg (w_neg[i+1]),
      .o_ch  (w_ch[i+1])
    );
  end

  // ---------------------------------------------------------------------
  // Output stage: undo the fold, optional sin negation, saturate
  // ---------------------------------------------------------------------
  logic signed [XW-1:0] w_xo;
  logic signed [XW-1:0] w_yo;
  logic signed [XW-1:0] w_so;

  assign w_xo = w_neg[ITER_NUM] ? -w_x[ITER_NUM] : w_x[ITER_NUM];
  assign w_yo = w_neg[ITER_NUM] ? -w_y[ITER_NUM] : w_y[ITER_NUM];
  assign w_so = EN_SIN_N ? -w_yo : w_yo;

  function automatic logic signed [ODAT_W-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[ODAT_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[ODAT_W-1:0];
    return v[ODAT_W-1:0];
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cos_o <= '0;
      sin_o <= '0;
      ch_o  <= '0;
      val_o <= 1'b0;
    end else begin
      val_o <= w_val[ITER_NUM];
      if (w_val[ITER_NUM]) begin
        cos_o <= sat(w_xo);
        sin_o <= sat(w_so);
        ch_o  <= w_ch[ITER_NUM];
      end
    end
  end

endmodule

// File: tb/tb_cordic_nco_tdm.sv
// Directed self-checking bench for cordic_nco_tdm (default parameters).
// Expected outputs are hand-computed trigonometric values at amplitude 32000.
// The comparison tolerance is 4 LSB.
module tb_cordic_nco_tdm;

  localparam int A      = 32000;
  localparam int COS_22 = 29564;   // 32000*cos(22.5 deg)
  localparam int SIN_22 = 12246;   // 32000*sin(22.5 deg)
  localparam int SIN_7F = 3;       // 32000*sin(2*pi*0x7FFF/2^16)
  localparam int TOL    = 4;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               en_i;
  logic               phase_clr_i;
  logic               cfg_we_i;
  logic [1:0]         cfg_ch_i;
  logic [15:0]        cfg_inc_i;
  logic [15:0]        cfg_ofs_i;
  logic signed [15:0] cos_o;
  logic signed [15:0] sin_o;
  logic [1:0]         ch_o;
  logic               val_o;

  typedef struct {
    int ch;
    int c;
    int s;
    int t;
  } samp_t;

  samp_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    first;
  bit    pat [10] = '{1, 0, 0, 1, 1, 0, 1, 1, 0, 1};
  int    ch1_cos [4] = '{A, 0, -A, 0};
  int    ch1_sin [4] = '{0, A, 0, -A};
  int    clr_ch  [4] = '{2, 3, 0, 1};
  int    clr_cos [4] = '{-A, A, A, A};

  cordic_nco_tdm dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .phase_clr_i (phase_clr_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_inc_i   (cfg_inc_i),
    .cfg_ofs_i   (cfg_ofs_i),
    .cos_o       (cos_o),
    .sin_o       (sin_o),
    .ch_o        (ch_o),
    .val_o       (val_o)
  );

  always #5 clk_i = ~clk_i;

  // Output monitor: records every valid sample with its cycle number.
  always @(posedge clk_i) begin
    cyc++;
    #1;
    if (val_o) q.push_back(samp_t'{int'(ch_o), int'(cos_o), int'(sin_o), cyc});
  end

  task automatic check(input string tag, input int observed, input int expected,
                       input int tol = 0);
    int diff;
    n_checks++;
    diff = observed - expected;
    if (diff > tol || diff < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_cfg(input int ch, input int inc, input int ofs);
    cfg_we_i  = 1'b1;
    cfg_ch_i  = 2'(ch);
    cfg_inc_i = 16'(inc);
    cfg_ofs_i = 16'(ofs);
    tick();
    cfg_we_i  = 1'b0;
  endtask

  task automatic wait_samples(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && q.size() < n; k++) tick();
    check(tag, q.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; en_i = 1'b0; phase_clr_i = 1'b0; cfg_we_i = 1'b0;
    cfg_ch_i = '0; cfg_inc_i = '0; cfg_ofs_i = '0;
    repeat (3) tick();
    check("rst_cos", int'(cos_o), 0);
    check("rst_sin", int'(sin_o), 0);
    check("rst_ch",  int'(ch_o), 0);
    check("rst_val", int'(val_o), 0);
    rst_i = 1'b0;

    // Basic rotation, sequencing and fold boundaries.
    write_cfg(0, 16'h0000, 16'h0000);
    write_cfg(1, 16'h4000, 16'h0000);
    write_cfg(2, 16'h0000, 16'h8000);
    write_cfg(3, 16'h0000, 16'h7FFF);
    q.delete();
    first = 0;
    en_i  = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 16) en_i = 1'b0;
      if (val_o && first == 0) first = n;
    end
    check("latency", first, 19);
    wait_samples(16, 40, "p1_count");
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      check("p1_ch", q[k].ch, k % 4);
      case (k % 4)
        0: begin check("ch0_cos", q[k].c, A, TOL);  check("ch0_sin", q[k].s, 0, TOL); end
        1: begin
          check("ch1_cos", q[k].c, ch1_cos[k/4], TOL);
          check("ch1_sin", q[k].s, ch1_sin[k/4], TOL);
        end
        2: begin check("ch2_cos", q[k].c, -A, TOL); check("ch2_sin", q[k].s, 0, TOL); end
        default: begin
          check("ch3_cos", q[k].c, -A, TOL);
          check("ch3_sin", q[k].s, SIN_7F, TOL);
        end
      endcase
    end

    // Config write in the same cycle that ch3 is issued.
    q.delete();
    en_i = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (n == 3) begin
        cfg_we_i = 1'b1; cfg_ch_i = 2'd3; cfg_inc_i = 16'h1000; cfg_ofs_i = 16'h0000;
      end else begin
        cfg_we_i = 1'b0;
      end
      tick();
    end
    en_i = 1'b0; cfg_we_i = 1'b0;
    wait_samples(12, 40, "p4_count");
    if (q.size() >= 12) begin
      check("wr_ch",       q[3].ch, 3);
      check("wr_old_cos",  q[3].c, -A, TOL);
      check("wr_old_sin",  q[3].s, SIN_7F, TOL);
      check("wr_next_cos", q[7].c, A, TOL);
      check("wr_next_sin", q[7].s, 0, TOL);
      check("wr_adv_cos",  q[11].c, COS_22, TOL);
      check("wr_adv_sin",  q[11].s, SIN_22, TOL);
    end

    // en_i toggling: no channel skipped, bubbles only.
    q.delete();
    for (int n = 0; n < 10; n++) begin
      en_i = pat[n];
      tick();
    end
    en_i = 1'b0;
    wait_samples(6, 40, "tog_count");
    for (int k = 0; k < 6 && k < q.size(); k++) check("tog_ch", q[k].ch, k % 4);
    if (q.size() >= 6) check("tog_span", q[5].t - q[0].t, 9);

    // Phase clear: next issued phase of every channel equals its offset.
    phase_clr_i = 1'b1;
    tick();
    phase_clr_i = 1'b0;
    q.delete();
    en_i = 1'b1;
    repeat (4) tick();
    en_i = 1'b0;
    wait_samples(4, 40, "clr_count");
    for (int k = 0; k < 4 && k < q.size(); k++) begin
      check("clr_ch",  q[k].ch, clr_ch[k]);
      check("clr_cos", q[k].c, clr_cos[k], TOL);
      check("clr_sin", q[k].s, 0, TOL);
    end

    // Reset in the middle of a running stream.
    en_i = 1'b1;
    repeat (25) tick();
    check("pre_rst_val", int'(val_o), 1);
    rst_i = 1'b1;
    tick();
    check("mrst_val", int'(val_o), 0);
    check("mrst_cos", int'(cos_o), 0);
    check("mrst_sin", int'(sin_o), 0);
    check("mrst_ch",  int'(ch_o), 0);
    tick();
    rst_i = 1'b0;
    q.delete();
    first = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 8) en_i = 1'b0;
      if (val_o && first == 0) first = n;
    end
    check("mrst_latency", first, 19);
    wait_samples(8, 40, "mrst_count");
    for (int k = 0; k < 8 && k < q.size(); k++) begin
      check("mrst_sch", q[k].ch, k % 4);
      check("mrst_scos", q[k].c, A, TOL);
      check("mrst_ssin", q[k].s, 0, TOL);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
